// File: rtl/imem_fetch_arbiter.sv
// Arbitrates the single instruction-memory read port between CPU fetch and a debug reader.
// Define IMEM_ARB_RR_EN for round-robin ties; default is CPU priority with a dbg starvation guard.
module imem_fetch_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INSTR_WIDTH  = 32,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cpu_req_valid,
  output logic                   cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0]  cpu_req_addr,
  output logic                   cpu_rsp_valid,
  input  logic                   cpu_rsp_ready,
  output logic [INSTR_WIDTH-1:0] cpu_rsp_instr,
  output logic                   cpu_rsp_err,
  input  logic                   dbg_req_valid,
  output logic                   dbg_req_ready,
  input  logic [ADDR_WIDTH-1:0]  dbg_req_addr,
  output logic                   dbg_rsp_valid,
  input  logic                   dbg_rsp_ready,
  output logic [INSTR_WIDTH-1:0] dbg_rsp_data,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_instr
);

  typedef enum logic [1:0] {IDLE, INFLIGHT, HOLD} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  state_t                 state;
  logic                   owner;
  logic                   err_q;
  logic [INSTR_WIDTH-1:0] hold_q;
  logic [ADDR_WIDTH-1:0]  addr_q;

  logic                   owner_rdy, opp, dbg_first, dbg_win, cpu_win, accept, rsp_live;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [INSTR_WIDTH-1:0] rsp_word;

  // A new read may issue only when the previous one has nowhere to stall.
  assign owner_rdy = (owner == OWN_DBG) ? dbg_rsp_ready : cpu_rsp_ready;
  assign opp       = !reset && (state == IDLE || (state == INFLIGHT && owner_rdy));

`ifdef IMEM_ARB_RR_EN
  logic last_win;
  assign dbg_first = (last_win == OWN_CPU);
`else
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve;
  assign dbg_first = (starve == SW'(STARVE_LIMIT));
`endif

  assign dbg_win  = opp && dbg_req_valid && (!cpu_req_valid || dbg_first);
  assign cpu_win  = opp && cpu_req_valid && !dbg_win;
  assign accept   = cpu_win || dbg_win;
  assign win_addr = dbg_win ? dbg_req_addr : cpu_req_addr;

  assign cpu_req_ready = cpu_win;
  assign dbg_req_ready = dbg_win;
  assign mem_addr      = accept ? win_addr : addr_q;

  assign rsp_live      = (state == INFLIGHT) || (state == HOLD);
  assign rsp_word      = (state == HOLD) ? hold_q : mem_instr;
  assign cpu_rsp_valid = rsp_live && (owner == OWN_CPU);
  assign dbg_rsp_valid = rsp_live && (owner == OWN_DBG);
  assign cpu_rsp_instr = rsp_word;
  assign dbg_rsp_data  = rsp_word;
  assign cpu_rsp_err   = cpu_rsp_valid && err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= OWN_CPU;
      err_q  <= 1'b0;
      hold_q <= '0;
      addr_q <= '0;
    end else if (accept) begin
      state  <= INFLIGHT;
      owner  <= dbg_win;
      err_q  <= |win_addr[1:0];
      addr_q <= win_addr;
    end else begin
      case (state)
        INFLIGHT: begin
          if (owner_rdy) state <= IDLE;
          else begin
            hold_q <= mem_instr;
            state  <= HOLD;
          end
        end
        HOLD:    if (owner_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMEM_ARB_RR_EN
  // Reset to dbg so the first tie after reset goes to the CPU.
  always_ff @(posedge clock) begin
    if (reset)       last_win <= OWN_DBG;
    else if (accept) last_win <= dbg_win;
  end
`else
  always_ff @(posedge clock) begin
    if (reset || !dbg_req_valid || dbg_win) starve <= '0;
    else if (opp && starve != SW'(STARVE_LIMIT)) starve <= starve + 1'b1;
  end
`endif

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter with a one-cycle-latency memory model.
module tb_imem_fetch_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req_valid, cpu_req_ready, cpu_rsp_valid, cpu_rsp_ready, cpu_rsp_err;
  logic [31:0] cpu_req_addr, cpu_rsp_instr;
  logic        dbg_req_valid, dbg_req_ready, dbg_rsp_valid, dbg_rsp_ready;
  logic [31:0] dbg_req_addr, dbg_rsp_data;
  logic [31:0] mem_addr, mem_instr;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  imem_fetch_arbiter #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .STARVE_LIMIT(15)) dut (
    .clock(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_addr(cpu_req_addr),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready), .cpu_rsp_instr(cpu_rsp_instr),
    .cpu_rsp_err(cpu_rsp_err),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_addr(dbg_req_addr),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready), .dbg_rsp_data(dbg_rsp_data),
    .mem_addr(mem_addr), .mem_instr(mem_instr)
  );

  function automatic logic [31:0] memw(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  always @(posedge clk) mem_instr <= memw(int'(mem_addr[16:2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_dbg, prev_dbg;
    reset = 1'b1;
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h0; cpu_rsp_ready = 1'b1;
    dbg_req_valid = 1'b1; dbg_req_addr = 32'h0; dbg_rsp_ready = 1'b1;
    nxt(); #1;
    chk("rst_cpu_rdy", cpu_req_ready, 0);
    chk("rst_dbg_rdy", dbg_req_ready, 0);
    chk("rst_cpu_vld", cpu_rsp_valid, 0);
    chk("rst_dbg_vld", dbg_rsp_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // CPU streaming at full rate
    nxt(); reset = 0; dbg_req_valid = 0; cpu_req_valid = 1; cpu_req_addr = 32'h0; #1;
    chk("s_rdy0", cpu_req_ready, 1);
    chk("s_addr0", mem_addr, 32'h0);
    nxt(); cpu_req_addr = 32'h4; #1;
    chk("s_vld0", cpu_rsp_valid, 1);
    chk("s_ins0", cpu_rsp_instr, memw(0));
    chk("s_rdy1", cpu_req_ready, 1);
    chk("s_addr1", mem_addr, 32'h4);
    chk("s_dbg0", dbg_rsp_valid, 0);
    nxt(); cpu_req_addr = 32'h8; #1;
    chk("s_ins1", cpu_rsp_instr, memw(1));
    chk("s_dbg1", dbg_rsp_valid, 0);
    nxt(); cpu_req_valid = 0; #1;
    chk("s_ins2", cpu_rsp_instr, memw(2));
    chk("s_rdy_none", cpu_req_ready, 0);
    chk("s_addr_keep", mem_addr, 32'h8);
    nxt(); #1;
    chk("s_idle", cpu_rsp_valid, 0);

    // backpressure into HOLD
    nxt(); cpu_req_valid = 1; cpu_req_addr = 32'h10; cpu_rsp_ready = 0; #1;
    chk("h_acc", cpu_req_ready, 1);
    nxt(); cpu_req_addr = 32'h14; #1;
    chk("h_vld_if", cpu_rsp_valid, 1);
    chk("h_ins_if", cpu_rsp_instr, memw(4));
    chk("h_rdy_if", cpu_req_ready, 0);
    for (int i = 0; i < 2; i++) begin
      nxt(); #1;
      chk($sformatf("h_vld%0d", i), cpu_rsp_valid, 1);
      chk($sformatf("h_ins%0d", i), cpu_rsp_instr, memw(4));
      chk($sformatf("h_rdy%0d", i), cpu_req_ready, 0);
    end
    nxt(); cpu_rsp_ready = 1; #1;
    chk("h_rel_vld", cpu_rsp_valid, 1);
    chk("h_rel_ins", cpu_rsp_instr, memw(4));
    chk("h_rel_rdy", cpu_req_ready, 0);
    nxt(); #1;
    chk("h_idle_vld", cpu_rsp_valid, 0);
    chk("h_idle_acc", cpu_req_ready, 1);
    nxt(); cpu_req_valid = 0; #1;
    chk("h_next_ins", cpu_rsp_instr, memw(5));

    // misaligned address
    nxt(); cpu_req_valid = 1; cpu_req_addr = 32'h6; #1;
    chk("e_acc", cpu_req_ready, 1);
    nxt(); cpu_req_addr = 32'h8; #1;
    chk("e_err1", cpu_rsp_err, 1);
    chk("e_ins1", cpu_rsp_instr, memw(1));
    chk("e_acc2", cpu_req_ready, 1);
    nxt(); cpu_req_valid = 0; #1;
    chk("e_err0", cpu_rsp_err, 0);
    chk("e_ins2", cpu_rsp_instr, memw(2));

    // reset while INFLIGHT
    nxt(); cpu_req_valid = 1; cpu_req_addr = 32'h10; #1;
    chk("ri_acc", cpu_req_ready, 1);
    nxt(); reset = 1; #1;
    chk("ri_rdy", cpu_req_ready, 0);
    nxt(); reset = 0; cpu_req_valid = 0; #1;
    chk("ri_cpu_vld", cpu_rsp_valid, 0);
    chk("ri_dbg_vld", dbg_rsp_valid, 0);
    nxt(); #1;
    chk("ri_stale", cpu_rsp_valid, 0);

    // reset while HOLD
    nxt(); cpu_req_valid = 1; cpu_req_addr = 32'h10; cpu_rsp_ready = 0; #1;
    chk("rh_acc", cpu_req_ready, 1);
    nxt(); cpu_req_valid = 0; #1;
    chk("rh_if", cpu_rsp_valid, 1);
    nxt(); #1;
    chk("rh_hold", cpu_rsp_valid, 1);
    reset = 1;
    nxt(); reset = 0; cpu_rsp_ready = 1; #1;
    chk("rh_cpu_vld", cpu_rsp_valid, 0);
    chk("rh_dbg_vld", dbg_rsp_valid, 0);
    nxt(); #1;
    chk("rh_stale", cpu_rsp_valid, 0);

    // both requesters valid continuously
    nxt();
    cpu_req_valid = 1; cpu_req_addr = 32'h20;
    dbg_req_valid = 1; dbg_req_addr = 32'h40;
    prev_dbg = 1'b0;
    for (int k = 0; k < 34; k++) begin
      #1;
`ifdef IMEM_ARB_RR_EN
      exp_dbg = (k % 2) == 1;
`else
      exp_dbg = (k % 16) == 15;
`endif
      chk($sformatf("t_cpu_rdy%0d", k), cpu_req_ready, !exp_dbg);
      chk($sformatf("t_dbg_rdy%0d", k), dbg_req_ready, exp_dbg);
      if (k > 0) begin
        chk($sformatf("t_dbg_vld%0d", k), dbg_rsp_valid, prev_dbg);
        chk($sformatf("t_cpu_vld%0d", k), cpu_rsp_valid, !prev_dbg);
        if (prev_dbg) chk($sformatf("t_dbg_dat%0d", k), dbg_rsp_data, memw(16));
        else          chk($sformatf("t_cpu_ins%0d", k), cpu_rsp_instr, memw(8));
      end
      prev_dbg = exp_dbg;
      nxt();
    end
    cpu_req_valid = 0; dbg_req_valid = 0;
    nxt(); nxt(); #1;
    chk("end_idle_cpu", cpu_rsp_valid, 0);
    chk("end_idle_dbg", dbg_rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
